// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared state encoding, defaults and width helper for the interrupt dispatcher.
package irq_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam int NUM_IRQ_DEF = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational fixed-priority encoder, lowest set index wins.
module irq_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] eligible,
    output logic [W-1:0] winner,
    output logic         any
);
    always_comb begin
        winner = '0;
        any    = |eligible;
        for (int i = N - 1; i >= 0; i--)
            if (eligible[i]) winner = W'(i);
    end
endmodule

// File: rtl/irq_dispatch_ctrl.sv
// irq_dispatch_ctrl: sticky pending capture, masking, fixed-priority dispatch and
// request/ack/EOI handshake with optional ack timeout; one interrupt in service at a time.
module irq_dispatch_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEF,
    parameter int VEC_W   = clog2(NUM_IRQ),
    parameter int ACK_TO  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [NUM_IRQ-1:0] irq_trigger,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               cpu_ack,
    input  logic               cpu_eoi,
    output logic               int_req,
    output logic [VEC_W-1:0]   irq_vector,
    output logic [NUM_IRQ-1:0] in_service,
    output logic [NUM_IRQ-1:0] pending,
    output logic               ack_timeout
);
    localparam int CNT_W = ACK_TO > 0 ? clog2(ACK_TO + 1) : 1;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [NUM_IRQ-1:0] eligible, clr, vec_oh, pending_n, in_service_n;
    logic [VEC_W-1:0]   winner, irq_vector_n;
    logic               any, int_req_n, ack_timeout_n;

    assign eligible = pending & ~irq_mask;
    assign vec_oh   = NUM_IRQ'(1) << irq_vector;

    irq_prio_enc #(.N(NUM_IRQ), .W(VEC_W)) u_enc (
        .eligible(eligible),
        .winner  (winner),
        .any     (any)
    );

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        int_req_n     = int_req;
        irq_vector_n  = irq_vector;
        in_service_n  = in_service;
        ack_timeout_n = 1'b0;
        clr           = '0;
        case (state)
            IDLE: if (any) begin
                state_n      = REQ;
                irq_vector_n = winner;
                int_req_n    = 1'b1;
                cnt_n        = '0;
            end
            REQ: if (cpu_ack) begin
                state_n      = SERVICE;
                clr          = vec_oh;
                in_service_n = vec_oh;
                int_req_n    = 1'b0;
            end else if (!eligible[irq_vector]) begin
                state_n   = IDLE;
                int_req_n = 1'b0;
            end else if (ACK_TO != 0 && cnt == CNT_W'(ACK_TO - 1)) begin
                state_n       = IDLE;
                int_req_n     = 1'b0;
                ack_timeout_n = 1'b1;
            end else begin
                cnt_n = (cnt == '1) ? cnt : cnt + 1'b1;
            end
            SERVICE: if (cpu_eoi) begin
                state_n      = IDLE;
                in_service_n = '0;
            end
            default: state_n = IDLE;
        endcase
        // a trigger in the same cycle as the ack re-arms the line
        pending_n = (pending & ~clr) | irq_trigger;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            int_req     <= 1'b0;
            irq_vector  <= '0;
            in_service  <= '0;
            pending     <= '0;
            ack_timeout <= 1'b0;
        end else if (enable) begin
            state       <= state_n;
            cnt         <= cnt_n;
            int_req     <= int_req_n;
            irq_vector  <= irq_vector_n;
            in_service  <= in_service_n;
            pending     <= pending_n;
            ack_timeout <= ack_timeout_n;
        end
    end
endmodule

// File: tb/tb_irq_dispatch_ctrl.sv
// tb_irq_dispatch_ctrl: table-driven vectors plus hand sequences, expectations queued per
// driven cycle and compared once the following clock edge has produced the outputs.
module tb_irq_dispatch_ctrl;
    logic       clk = 1'b0, rst = 1'b1, enable = 1'b0, cpu_ack = 1'b0, cpu_eoi = 1'b0;
    logic [3:0] irq_trigger = '0, irq_mask = '0;
    logic       int_req, ack_timeout;
    logic [1:0] irq_vector;
    logic [3:0] in_service, pending;
    int total = 0, bad = 0;

    typedef struct packed {
        logic       ir;
        logic [1:0] vec;
        logic [3:0] svc, pnd;
        logic       to;
    } exp_t;

    typedef struct packed {
        logic [3:0] tr, mk;
        logic       ack, eoi, en;
        exp_t       e;
    } row_t;

    row_t rows[$];
    exp_t sb[$];

    irq_dispatch_ctrl #(.NUM_IRQ(4), .VEC_W(2), .ACK_TO(15)) dut (
        .clk(clk), .rst(rst), .enable(enable), .irq_trigger(irq_trigger), .irq_mask(irq_mask),
        .cpu_ack(cpu_ack), .cpu_eoi(cpu_eoi), .int_req(int_req), .irq_vector(irq_vector),
        .in_service(in_service), .pending(pending), .ack_timeout(ack_timeout)
    );

    always #5 clk = ~clk;

    function automatic row_t R(logic [3:0] tr, logic [3:0] mk, logic ack, logic eoi, logic en,
                               logic ir, logic [1:0] vec, logic [3:0] svc, logic [3:0] pnd, logic to);
        return {tr, mk, ack, eoi, en, ir, vec, svc, pnd, to};
    endfunction

    task automatic chk(string n, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
        end
    endtask

    task automatic check_out(exp_t e);
        chk("int_req", int_req, e.ir);
        chk("irq_vector", irq_vector, e.vec);
        chk("in_service", in_service, e.svc);
        chk("pending", pending, e.pnd);
        chk("ack_timeout", ack_timeout, e.to);
    endtask

    task automatic step(row_t r);
        exp_t e;
        irq_trigger = r.tr;
        irq_mask    = r.mk;
        cpu_ack     = r.ack;
        cpu_eoi     = r.eoi;
        enable      = r.en;
        sb.push_back(r.e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_out(e);
    endtask

    initial begin
        //              tr     mk    ack eoi en  ir vec svc    pnd    to
        // single line, ack, eoi
        rows.push_back(R(4'h4, 4'h0, 0, 0, 1,  0, 0, 4'h0, 4'h4, 0));
        rows.push_back(R(4'h0, 4'h0, 0, 0, 1,  1, 2, 4'h0, 4'h4, 0));
        rows.push_back(R(4'h0, 4'h0, 1, 0, 1,  0, 2, 4'h4, 4'h0, 0));
        rows.push_back(R(4'h0, 4'h0, 0, 0, 1,  0, 2, 4'h4, 4'h0, 0));
        rows.push_back(R(4'h0, 4'h0, 0, 1, 1,  0, 2, 4'h0, 4'h0, 0));
        // two simultaneous lines, priority order
        rows.push_back(R(4'hA, 4'h0, 0, 0, 1,  0, 2, 4'h0, 4'hA, 0));
        rows.push_back(R(4'h0, 4'h0, 0, 0, 1,  1, 1, 4'h0, 4'hA, 0));
        rows.push_back(R(4'h0, 4'h0, 1, 0, 1,  0, 1, 4'h2, 4'h8, 0));
        rows.push_back(R(4'h0, 4'h0, 0, 1, 1,  0, 1, 4'h0, 4'h8, 0));
        rows.push_back(R(4'h0, 4'h0, 0, 0, 1,  1, 3, 4'h0, 4'h8, 0));
        rows.push_back(R(4'h0, 4'h0, 1, 0, 1,  0, 3, 4'h8, 4'h0, 0));
        rows.push_back(R(4'h0, 4'h0, 0, 1, 1,  0, 3, 4'h0, 4'h0, 0));
        // masked line keeps pending, dispatches on unmask
        rows.push_back(R(4'h1, 4'h1, 0, 0, 1,  0, 3, 4'h0, 4'h1, 0));
        rows.push_back(R(4'h0, 4'h1, 0, 0, 1,  0, 3, 4'h0, 4'h1, 0));
        rows.push_back(R(4'h0, 4'h1, 0, 0, 1,  0, 3, 4'h0, 4'h1, 0));
        rows.push_back(R(4'h0, 4'h0, 0, 0, 1,  1, 0, 4'h0, 4'h1, 0));
        rows.push_back(R(4'h0, 4'h0, 1, 0, 1,  0, 0, 4'h1, 4'h0, 0));
        rows.push_back(R(4'h0, 4'h0, 0, 1, 1,  0, 0, 4'h0, 4'h0, 0));
        rows.push_back(R(4'h0, 4'h0, 1, 1, 1,  0, 0, 4'h0, 4'h0, 0));
        // withdraw on mid-request mask, late higher-priority arrival, ack beats withdraw
        rows.push_back(R(4'h2, 4'h0, 0, 0, 1,  0, 0, 4'h0, 4'h2, 0));
        rows.push_back(R(4'h0, 4'h0, 0, 0, 1,  1, 1, 4'h0, 4'h2, 0));
        rows.push_back(R(4'h1, 4'h0, 0, 0, 1,  1, 1, 4'h0, 4'h3, 0));
        rows.push_back(R(4'h0, 4'h2, 0, 0, 1,  0, 1, 4'h0, 4'h3, 0));
        rows.push_back(R(4'h0, 4'h2, 0, 0, 1,  1, 0, 4'h0, 4'h3, 0));
        rows.push_back(R(4'h0, 4'h2, 1, 0, 1,  0, 0, 4'h1, 4'h2, 0));
        rows.push_back(R(4'h0, 4'h2, 0, 1, 1,  0, 0, 4'h0, 4'h2, 0));
        rows.push_back(R(4'h0, 4'h0, 0, 0, 1,  1, 1, 4'h0, 4'h2, 0));
        rows.push_back(R(4'h2, 4'h2, 1, 0, 1,  0, 1, 4'h2, 4'h2, 0));
        rows.push_back(R(4'h0, 4'h0, 0, 1, 1,  0, 1, 4'h0, 4'h2, 0));
        rows.push_back(R(4'h0, 4'h0, 0, 0, 1,  1, 1, 4'h0, 4'h2, 0));
        rows.push_back(R(4'h0, 4'h0, 1, 0, 1,  0, 1, 4'h2, 4'h0, 0));
        rows.push_back(R(4'h0, 4'h0, 0, 1, 1,  0, 1, 4'h0, 4'h0, 0));

        repeat (2) @(posedge clk);
        #1;
        check_out('0);
        @(negedge clk);
        rst = 1'b0;
        foreach (rows[i]) step(rows[i]);

        // ack timeout: 15 cycles of int_req, one pulse, immediate re-request
        step(R(4'h8, 4'h0, 0, 0, 1, 0, 1, 4'h0, 4'h8, 0));
        for (int i = 0; i < 15; i++) step(R(4'h0, 4'h0, 0, 0, 1, 1, 3, 4'h0, 4'h8, 0));
        step(R(4'h0, 4'h0, 0, 0, 1, 0, 3, 4'h0, 4'h8, 1));
        step(R(4'h0, 4'h0, 0, 0, 1, 1, 3, 4'h0, 4'h8, 0));
        step(R(4'h0, 4'h0, 1, 0, 1, 0, 3, 4'h8, 4'h0, 0));
        step(R(4'h0, 4'h0, 0, 1, 1, 0, 3, 4'h0, 4'h0, 0));

        // freeze mid-request: counter must resume where it stopped
        step(R(4'h4, 4'h0, 0, 0, 1, 0, 3, 4'h0, 4'h4, 0));
        step(R(4'h0, 4'h0, 0, 0, 1, 1, 2, 4'h0, 4'h4, 0));
        step(R(4'h0, 4'h0, 0, 0, 1, 1, 2, 4'h0, 4'h4, 0));
        for (int i = 0; i < 5; i++) step(R(4'h1, 4'h0, 1, 0, 0, 1, 2, 4'h0, 4'h4, 0));
        for (int i = 0; i < 13; i++) step(R(4'h0, 4'h0, 0, 0, 1, 1, 2, 4'h0, 4'h4, 0));
        step(R(4'h0, 4'h0, 0, 0, 1, 0, 2, 4'h0, 4'h4, 1));
        step(R(4'h0, 4'h0, 0, 0, 1, 1, 2, 4'h0, 4'h4, 0));
        step(R(4'h2, 4'h0, 1, 0, 1, 0, 2, 4'h4, 4'h2, 0));

        // asynchronous reset while in service
        irq_trigger = '0;
        cpu_ack     = 1'b0;
        #2 rst = 1'b1;
        #1 check_out('0);
        @(negedge clk);
        rst = 1'b0;
        step(R(4'h0, 4'h0, 0, 0, 1, 0, 0, 4'h0, 4'h0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
